// File: rtl/distribute_1x2_out_buffer_seq_pkg.sv
// Shared constants for the 1x2 distribute output buffer.
// Branch indices, default geometry, drop-counter width and a saturating increment helper.
// Optional feature macro used across this slice: DROP_COUNT_EN.
package distribute_1x2_out_buffer_seq_pkg;

   localparam int N_BRANCH           = 2;
   localparam int BR_LOW             = 0;
   localparam int BR_HIGH            = 1;
   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_DEPTH      = 4;
   localparam int DEFAULT_HEADROOM   = 2;
   localparam int DROP_CNT_W         = 16;

   // Saturating +1 for the per-branch drop counters (sticks at all-ones).
   function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/distribute_1x2_out_buffer_seq_if.sv
// Bus between the distribute switch / consumers and the per-branch output buffer.
// Lanes are packed {high, low}. Optional feature macro: DROP_COUNT_EN (adds o_drop_cnt).
//
// Handshake: a word leaves branch b on a rising edge where o_valid[b] & i_ready[b]
// are both 1; o_valid[b] never depends on i_ready[b]. The upstream side has no
// ready: it must drop i_en (stop pushing) while o_stall is 1, and a push into a
// full branch with no pop in the same cycle is discarded and flagged.
interface distribute_1x2_out_buffer_seq_if
   #(parameter int DATA_WIDTH = distribute_1x2_out_buffer_seq_pkg::DEFAULT_DATA_WIDTH);

   import distribute_1x2_out_buffer_seq_pkg::*;

   logic [N_BRANCH-1:0]            i_valid;
   logic [N_BRANCH*DATA_WIDTH-1:0] i_data_bus;
   logic                           o_stall;
   logic [N_BRANCH-1:0]            o_valid;
   logic [N_BRANCH*DATA_WIDTH-1:0] o_data_bus;
   logic [N_BRANCH-1:0]            i_ready;
   logic                           i_clr;
   logic [N_BRANCH-1:0]            o_overflow;
`ifdef DROP_COUNT_EN
   logic [N_BRANCH*DROP_CNT_W-1:0] o_drop_cnt;
`endif

`ifdef DROP_COUNT_EN
   modport master (output i_valid, i_data_bus, i_ready, i_clr,
                   input  o_stall, o_valid, o_data_bus, o_overflow, o_drop_cnt);
   modport slave  (input  i_valid, i_data_bus, i_ready, i_clr,
                   output o_stall, o_valid, o_data_bus, o_overflow, o_drop_cnt);
`else
   modport master (output i_valid, i_data_bus, i_ready, i_clr,
                   input  o_stall, o_valid, o_data_bus, o_overflow);
   modport slave  (input  i_valid, i_data_bus, i_ready, i_clr,
                   output o_stall, o_valid, o_data_bus, o_overflow);
`endif

endinterface

// File: rtl/distribute_1x2_out_buffer_seq_branch_fifo_seq.sv
// One branch of the output buffer: first-word-fall-through FIFO with an occupancy
// count, almost-full flag, sticky overflow flag and (DROP_COUNT_EN) a saturating
// drop counter. DEPTH must be a power of two so pointers wrap for free.
module branch_fifo_seq
   import distribute_1x2_out_buffer_seq_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int HEADROOM   = DEFAULT_HEADROOM
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push_valid,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop_ready,
   input  logic                  clr,
   output logic                  head_valid,
   output logic [DATA_WIDTH-1:0] head_data,
   output logic                  almost_full,
   output logic                  overflow
`ifdef DROP_COUNT_EN
   ,
   output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
   localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - HEADROOM);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic                  pop;
   logic                  push;
   logic                  drop;

   // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
   assign head_valid  = (count != '0);
   assign pop         = head_valid & pop_ready;
   assign push        = push_valid & ((count != FULL_LVL) | pop);
   assign drop        = push_valid & (count == FULL_LVL) & ~pop;
   assign almost_full = (count >= AF_LVL);
   assign head_data   = head_valid ? mem[rd_ptr] : '0;

   // Storage write; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers and occupancy count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow; a drop in the clearing cycle keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clr) begin
         overflow <= 1'b0;
      end
   end

`ifdef DROP_COUNT_EN
   // Saturating drop count; a drop during clear restarts the count at one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
      end else if (drop) begin
         drop_cnt <= clr ? DROP_CNT_W'(1) : sat_inc(drop_cnt);
      end else if (clr) begin
         drop_cnt <= '0;
      end
   end
`endif

endmodule

// File: rtl/distribute_1x2_out_buffer_seq.sv
// Per-branch output buffer behind the 1x2 distribute switch: splits the {high, low}
// lanes into two independent FIFOs, merges their heads back onto the bus, ORs the
// almost-full flags into o_stall and synchronises reset release.
// Optional feature macro: DROP_COUNT_EN (exposes o_drop_cnt = {high, low}).
module distribute_1x2_out_buffer_seq
   import distribute_1x2_out_buffer_seq_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int HEADROOM   = DEFAULT_HEADROOM
) (
   input logic                              clk,
   input logic                              rst,
   distribute_1x2_out_buffer_seq_if.slave   bus
);

   logic [1:0]            rst_sync;
   logic                  rst_n_sync;
   logic [N_BRANCH-1:0]   head_valid;
   logic [N_BRANCH-1:0]   almost_full;
   logic [N_BRANCH-1:0]   overflow;
   logic [DATA_WIDTH-1:0] head_data [N_BRANCH];
`ifdef DROP_COUNT_EN
   logic [DROP_CNT_W-1:0] drop_cnt [N_BRANCH];
`endif

   // Reset asserts immediately and releases two clocks later.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign rst_n_sync = rst_sync[1];

   for (genvar b = 0; b < N_BRANCH; b++) begin : g_branch
      branch_fifo_seq #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (DEPTH),
         .HEADROOM   (HEADROOM)
      ) u_fifo (
         .clk         (clk),
         .rst_n       (rst_n_sync),
         .push_valid  (bus.i_valid[b]),
         .push_data   (bus.i_data_bus[b*DATA_WIDTH +: DATA_WIDTH]),
         .pop_ready   (bus.i_ready[b]),
         .clr         (bus.i_clr),
         .head_valid  (head_valid[b]),
         .head_data   (head_data[b]),
         .almost_full (almost_full[b]),
         .overflow    (overflow[b])
`ifdef DROP_COUNT_EN
         ,
         .drop_cnt    (drop_cnt[b])
`endif
      );
   end

   // Stall depends only on registered counts, so there is no path from i_ready.
   assign bus.o_stall    = |almost_full;
   assign bus.o_valid    = head_valid;
   assign bus.o_data_bus = {head_data[BR_HIGH], head_data[BR_LOW]};
   assign bus.o_overflow = overflow;
`ifdef DROP_COUNT_EN
   assign bus.o_drop_cnt = {drop_cnt[BR_HIGH], drop_cnt[BR_LOW]};
`endif

endmodule

// File: tb/tb_distribute_1x2_out_buffer_seq.sv
// Self-checking bench for distribute_1x2_out_buffer_seq (DEPTH=4, HEADROOM=2).
// Reference model: two plain word queues of capacity DEPTH plus sticky flags.
// Driver pushes accepted words into exp_h/exp_l; a negedge monitor pops and
// compares whenever a branch hands a word to its consumer.
// Honours DROP_COUNT_EN when defined.
module tb_distribute_1x2_out_buffer_seq;

   localparam int DW       = 32;
   localparam int DEPTH    = 4;
   localparam int HEADROOM = 2;

   logic clk = 1'b0;
   logic rst;

   distribute_1x2_out_buffer_seq_if #(.DATA_WIDTH(DW)) bus ();

   distribute_1x2_out_buffer_seq #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .HEADROOM   (HEADROOM)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock.
   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   string       tag   = "init";

   logic [DW-1:0] mdl_h[$];
   logic [DW-1:0] mdl_l[$];
   logic [DW-1:0] exp_h[$];
   logic [DW-1:0] exp_l[$];
   logic [1:0]    ov = 2'b00;
   int            dc_h = 0;
   int            dc_l = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s/%s got=%0h want=%0h", tag, name, got, want);
      end
   endtask

   task automatic set_idle();
      bus.i_valid    = 2'b00;
      bus.i_data_bus = '0;
      bus.i_ready    = 2'b00;
      bus.i_clr      = 1'b0;
   endtask

   task automatic model_clear();
      mdl_h.delete();
      mdl_l.delete();
      exp_h.delete();
      exp_l.delete();
      ov   = 2'b00;
      dc_h = 0;
      dc_l = 0;
   endtask

   // Compare all visible outputs with the model state after the last edge.
   task automatic check_outputs();
      logic [DW-1:0] want_h;
      logic [DW-1:0] want_l;
      want_h = (mdl_h.size() != 0) ? mdl_h[0] : '0;
      want_l = (mdl_l.size() != 0) ? mdl_l[0] : '0;
      check("o_valid", 64'(bus.o_valid), 64'({mdl_h.size() != 0, mdl_l.size() != 0}));
      check("o_stall", 64'(bus.o_stall),
            64'((mdl_h.size() >= DEPTH - HEADROOM) || (mdl_l.size() >= DEPTH - HEADROOM)));
      check("o_overflow", 64'(bus.o_overflow), 64'(ov));
      check("head_h", 64'(bus.o_data_bus[2*DW-1:DW]), 64'(want_h));
      check("head_l", 64'(bus.o_data_bus[DW-1:0]), 64'(want_l));
`ifdef DROP_COUNT_EN
      check("o_drop_cnt", 64'(bus.o_drop_cnt), 64'({16'(dc_h), 16'(dc_l)}));
`endif
   endtask

   // One clock of stimulus: drive, advance the model, take the edge, check.
   task automatic step(input logic [1:0] v, input logic [DW-1:0] dh, input logic [DW-1:0] dl,
                       input logic [1:0] rdy, input logic clr);
      int sz_h, sz_l;
      logic pop_h, pop_l, acc_h, acc_l, drp_h, drp_l;
      bus.i_valid    = v;
      bus.i_data_bus = {dh, dl};
      bus.i_ready    = rdy;
      bus.i_clr      = clr;
      sz_h  = mdl_h.size();
      sz_l  = mdl_l.size();
      pop_h = (sz_h != 0) && rdy[1];
      pop_l = (sz_l != 0) && rdy[0];
      acc_h = v[1] && ((sz_h < DEPTH) || pop_h);
      acc_l = v[0] && ((sz_l < DEPTH) || pop_l);
      drp_h = v[1] && !acc_h;
      drp_l = v[0] && !acc_l;
      if (pop_h) void'(mdl_h.pop_front());
      if (pop_l) void'(mdl_l.pop_front());
      if (acc_h) begin mdl_h.push_back(dh); exp_h.push_back(dh); end
      if (acc_l) begin mdl_l.push_back(dl); exp_l.push_back(dl); end
      ov[1] = drp_h ? 1'b1 : (clr ? 1'b0 : ov[1]);
      ov[0] = drp_l ? 1'b1 : (clr ? 1'b0 : ov[0]);
      dc_h  = drp_h ? (clr ? 1 : (dc_h < 65535 ? dc_h + 1 : dc_h)) : (clr ? 0 : dc_h);
      dc_l  = drp_l ? (clr ? 1 : (dc_l < 65535 ? dc_l + 1 : dc_l)) : (clr ? 0 : dc_l);
      @(posedge clk);
      #1;
      set_idle();
      check_outputs();
   endtask

   // Scoreboard monitor: every word handed to a consumer must be the oldest expected one.
   always @(negedge clk) begin
      logic [DW-1:0] w;
      if (bus.o_valid[1] === 1'b1 && bus.i_ready[1] === 1'b1) begin
         if (exp_h.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s/pop_h got=%0h want=<none>", tag, bus.o_data_bus[2*DW-1:DW]);
         end else begin
            w = exp_h.pop_front();
            check("pop_h", 64'(bus.o_data_bus[2*DW-1:DW]), 64'(w));
         end
      end
      if (bus.o_valid[0] === 1'b1 && bus.i_ready[0] === 1'b1) begin
         if (exp_l.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s/pop_l got=%0h want=<none>", tag, bus.o_data_bus[DW-1:0]);
         end else begin
            w = exp_l.pop_front();
            check("pop_l", 64'(bus.o_data_bus[DW-1:0]), 64'(w));
         end
      end
   end

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   // Main sequence.
   initial begin
      set_idle();
      rst = 1'b1;
      #2 rst = 1'b0;
      #1;
      tag = "reset";
      check("o_valid", 64'(bus.o_valid), 64'(0));
      check("o_data_bus", 64'(bus.o_data_bus), 64'(0));
      check("o_stall", 64'(bus.o_stall), 64'(0));
      check("o_overflow", 64'(bus.o_overflow), 64'(0));
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      repeat (3) step(2'b00, '0, '0, 2'b00, 1'b0);

      // Reset mid-stream.
      tag = "reset_mid";
      for (int i = 0; i < 3; i++) step(2'b01, '0, DW'(32'h100 + i), 2'b00, 1'b0);
      #3 rst = 1'b0;
      #1;
      check("o_valid", 64'(bus.o_valid), 64'(0));
      check("o_data_bus", 64'(bus.o_data_bus), 64'(0));
      check("o_stall", 64'(bus.o_stall), 64'(0));
      model_clear();
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      repeat (3) step(2'b00, '0, '0, 2'b00, 1'b0);
      check("o_valid_after", 64'(bus.o_valid), 64'(0));

      // Duplicate fill.
      tag = "dup_fill";
      step(2'b11, 32'hA5A5_0001, 32'hA5A5_0001, 2'b00, 1'b0);
      check("stall_edge1", 64'(bus.o_stall), 64'(0));
      step(2'b11, 32'hA5A5_0002, 32'hA5A5_0002, 2'b00, 1'b0);
      check("stall_edge2", 64'(bus.o_stall), 64'(1));
      check("valid", 64'(bus.o_valid), 64'(2'b11));
      check("heads", 64'(bus.o_data_bus), 64'h A5A5_0001_A5A5_0001);
      repeat (3) step(2'b00, '0, '0, 2'b11, 1'b0);

      // Overflow.
      tag = "overflow";
      for (int i = 0; i < 5; i++) step(2'b01, '0, DW'(32'h300 + i), 2'b00, 1'b0);
      check("flag", 64'(bus.o_overflow), 64'(2'b01));
`ifdef DROP_COUNT_EN
      check("cnt_low", 64'(bus.o_drop_cnt[15:0]), 64'(1));
`endif

      // Clear colliding with a drop.
      tag = "clr_collision";
      step(2'b01, '0, 32'h0000_0350, 2'b00, 1'b0);
      step(2'b01, '0, 32'h0000_0351, 2'b00, 1'b1);
      check("flag", 64'(bus.o_overflow), 64'(2'b01));
`ifdef DROP_COUNT_EN
      check("cnt_low", 64'(bus.o_drop_cnt[15:0]), 64'(1));
`endif
      step(2'b00, '0, '0, 2'b00, 1'b1);
      check("flag_cleared", 64'(bus.o_overflow), 64'(0));

      // Full push+pop.
      tag = "full_push_pop";
      for (int i = 0; i < 3; i++) step(2'b01, '0, DW'(32'h400 + i), 2'b01, 1'b0);
      check("flag", 64'(bus.o_overflow), 64'(0));
      check("valid", 64'(bus.o_valid), 64'(2'b01));
      repeat (5) step(2'b00, '0, '0, 2'b11, 1'b0);

      // Independent drain.
      tag = "indep_drain";
      step(2'b11, 32'd1, 32'd7, 2'b00, 1'b0);
      step(2'b10, 32'd2, '0, 2'b00, 1'b0);
      step(2'b10, 32'd3, '0, 2'b00, 1'b0);
      repeat (3) step(2'b00, '0, '0, 2'b10, 1'b0);
      check("valid", 64'(bus.o_valid), 64'(2'b01));
      check("low_lane", 64'(bus.o_data_bus[DW-1:0]), 64'(7));
      repeat (2) step(2'b00, '0, '0, 2'b11, 1'b0);

      // Randomised traffic.
      tag = "random";
      for (int i = 0; i < 600; i++) begin
         step(2'($urandom_range(0, 3)), DW'($urandom), DW'($urandom),
              2'($urandom_range(0, 3)), ($urandom_range(0, 15) == 0));
      end
      repeat (6) step(2'b00, '0, '0, 2'b11, 1'b0);
      tag = "final";
      check("exp_h_left", 64'(exp_h.size()), 64'(0));
      check("exp_l_left", 64'(exp_l.size()), 64'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
